vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- CLK_DIV, 4: system clocks per pixel; allowed values 2..16.
- H_TOTAL, 800: pixels per line.
- H_SYNC, 96: hSync low width in pixels.
- H_START, 144: first visible hCount.
- H_END, 783: last visible hCount.
- V_TOTAL, 525: lines per frame.
- V_SYNC, 2: vSync low width in lines.
- V_START, 35: first visible vCount.
- V_END, 514: last visible vCount.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: system clock, 100 MHz.
- rst, in, 1: reset; one clock, with asynchronous, active-low reset (rst low = reset).
- enable, in, 1: run/freeze control for the timing.
- pix_en, out, 1: one-clk pulse per pixel period.
- hCount, out, 10: horizontal pixel counter.
- vCount, out, 10: vertical line counter.
- hSync, out, 1: horizontal sync, active low.
- vSync, out, 1: vertical sync, active low.
- bright, out, 1: high while inside the visible area.
- frame_tick, out, 1: one-clk pulse at the end of each frame.
- frame_count, out, 16: completed-frame counter.

Function
REQ-003 The divider counter SHALL count 0..CLK_DIV-1 on each clk while enable=1, wrapping to 0 after CLK_DIV-1.
REQ-004 pix_en SHALL be 1 exactly in clk cycles where enable=1 and the divider equals CLK_DIV-1, and 0 otherwise.
REQ-005 hCount SHALL increment by 1 on each clk edge where pix_en=1, and wrap H_TOTAL-1 -> 0.
REQ-006 vCount SHALL increment by 1 only on the edge where hCount wraps.
REQ-007 vCount SHALL wrap V_TOTAL-1 -> 0 on the edge where hCount wraps with vCount=V_TOTAL-1.
REQ-008 hCount and vCount SHALL never take values at or above H_TOTAL or V_TOTAL respectively.
REQ-009 hSync SHALL be a combinational decode of the registered hCount: 0 when hCount < H_SYNC, else 1.
REQ-010 vSync SHALL be a combinational decode of the registered vCount: 0 when vCount < V_SYNC, else 1.
REQ-011 bright SHALL be 1 iff H_START <= hCount <= H_END and V_START <= vCount <= V_END; the window bounds are inclusive.
REQ-012 hSync, vSync and bright SHALL be aligned to the same clk as hCount and vCount, so that downstream combinational rgb logic needs no extra pipeline stage.
REQ-013 frame_tick SHALL be 1 in exactly the clk cycle where pix_en=1, hCount=H_TOTAL-1 and vCount=V_TOTAL-1.
REQ-014 frame_tick SHALL be high for at most one clk per frame.
REQ-015 frame_count SHALL increment by 1 on each clk edge where frame_tick=1, wrapping from 16'hFFFF to 0.
REQ-016 While enable=0:
- the divider, hCount, vCount and frame_count SHALL hold their values;
- pix_en and frame_tick SHALL be 0;
- hSync and vSync SHALL be forced to 1;
- bright SHALL be forced to 0.
REQ-017 When enable returns to 1, counting SHALL resume from the held values with no skipped or repeated count.
REQ-018 A full frame SHALL last exactly CLK_DIV*H_TOTAL*V_TOTAL clk cycles of enable=1; with the defaults this is 1,680,000 cycles.

Reset
REQ-019 rst=0 SHALL immediately, without waiting for clk, set:
- divider = 0, hCount = 0, vCount = 0, frame_count = 0;
- pix_en = 0 and frame_tick = 0.
REQ-020 During reset, hSync, vSync and bright SHALL follow the decodes of the reset counters, giving hSync=0, vSync=0, bright=0 (or hSync=vSync=1 if enable=0).
REQ-021 Reset asserted mid-line or mid-frame SHALL abandon the frame in progress; no frame_tick SHALL be produced for the aborted frame.
REQ-022 After rst deasserts, the first pix_en SHALL occur on the CLK_DIV-th clk edge with enable=1.
REQ-023 After rst deasserts, hCount SHALL become 1 on the edge following that first pix_en.

Verification
REQ-024 Reset and first counts: release rst with enable=1 -> pix_en at clk 4, 8, 12, ... and hCount 0,1,2 at 4-clk spacing; hSync=0 until hCount=96, then 1.
REQ-025 Line wrap: run to hCount=799, vCount=0 -> next pix_en edge gives hCount=0, vCount=1; vSync=0 for vCount 0..1 and 1 at vCount=2.
REQ-026 Visible window edges: sweep the counters -> bright=0 at (143,35), 1 at (144,35), 1 at (783,514), 0 at (784,514) and 0 at (144,515).
REQ-027 Frame end: run 1,680,000 clks -> exactly one frame_tick, at hCount=799, vCount=524; frame_count goes 0 -> 1; counters then read (0,0).
REQ-028 Freeze: drop enable for 37 clks at hCount=500 -> counters hold at 500, hSync=vSync=1, bright=0, pix_en=0; on re-enable the next hCount is 501 after exactly the remaining divider cycles.
REQ-029 Async reset mid-frame: assert rst at (400,300) between clk edges -> outputs read 0 immediately, no frame_tick is seen, and frame_count=0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate strobe, h/v counters, sync/blank decodes, frame counter.
// Latency: decodes are combinational from the counter registers, aligned with hCount/vCount.
// Backpressure: enable=0 freezes all counters; strobes drop, syncs go inactive, bright goes low.
module vga_timing_gen #(
    parameter int CLK_DIV = 4,
    parameter int H_TOTAL = 800,
    parameter int H_SYNC  = 96,
    parameter int H_START = 144,
    parameter int H_END   = 783,
    parameter int V_TOTAL = 525,
    parameter int V_SYNC  = 2,
    parameter int V_START = 35,
    parameter int V_END   = 514
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        pix_en,
    output logic [9:0]  hCount,
    output logic [9:0]  vCount,
    output logic        hSync,
    output logic        vSync,
    output logic        bright,
    output logic        frame_tick,
    output logic [15:0] frame_count
);

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
    localparam logic [9:0] H_LO     = 10'(H_START);
    localparam logic [9:0] H_HI     = 10'(H_END);
    localparam logic [9:0] V_LO     = 10'(V_START);
    localparam logic [9:0] V_HI     = 10'(V_END);

    logic [3:0] div_q;
    logic       h_wrap;
    logic       v_wrap;
    logic       in_window;

    assign h_wrap     = (hCount == H_LAST);
    assign v_wrap     = (vCount == V_LAST);
    assign pix_en     = enable && (div_q == DIV_LAST);
    assign frame_tick = pix_en && h_wrap && v_wrap;

    assign in_window = (hCount >= H_LO) && (hCount <= H_HI) &&
                       (vCount >= V_LO) && (vCount <= V_HI);

    // Frozen timing presents an idle raster: syncs inactive, no visible pixels.
    assign hSync  = !enable || (hCount >= H_SYNC_W);
    assign vSync  = !enable || (vCount >= V_SYNC_W);
    assign bright = enable && in_window;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q       <= '0;
            hCount      <= '0;
            vCount      <= '0;
            frame_count <= '0;
        end else if (enable) begin
            div_q <= (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
            if (pix_en) begin
                hCount <= h_wrap ? 10'd0 : hCount + 10'd1;
                if (h_wrap) begin
                    vCount <= v_wrap ? 10'd0 : vCount + 10'd1;
                end
            end
            if (frame_tick) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule
